// File: rtl/board_draw_scheduler.sv
// board_draw_scheduler: shares the VGA pixel port between the grid and
// selector drawers, redrawing dirty cells of the 4x4 board lowest-first.
module board_draw_scheduler #(
    parameter logic [7:0] X0         = 8'd31,
    parameter logic [6:0] Y0         = 7'd11,
    parameter logic [7:0] CELL       = 8'd25,
    parameter logic [2:0] SEL_COLOUR = 3'b100,
    parameter logic [9:0] TIMEOUT    = 10'd1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cell_state,
    input  logic        mark_valid,
    input  logic [3:0]  mark_cell,
    input  logic        redraw_all,
    input  logic        sel_move,
    input  logic [3:0]  sel_cell,
    output logic        grid_draw,
    output logic [7:0]  grid_x,
    output logic [6:0]  grid_y,
    output logic [2:0]  grid_bg,
    output logic [2:0]  grid_fg,
    input  logic        grid_done,
    input  logic [7:0]  grid_px_x,
    input  logic [6:0]  grid_px_y,
    input  logic [2:0]  grid_px_colour,
    output logic        sel_draw,
    output logic [7:0]  sel_x,
    output logic [6:0]  sel_y,
    output logic [2:0]  sel_colour,
    input  logic        sel_done,
    input  logic [7:0]  sel_px_x,
    input  logic [6:0]  sel_px_y,
    input  logic [2:0]  sel_px_colour,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        timeout_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_PICK, S_GRID_START, S_GRID_WAIT, S_SEL_START, S_SEL_WAIT
    } state_t;

    state_t      r_state;
    logic [15:0] r_dirty;
    logic [3:0]  r_sel_q;
    logic [3:0]  r_idx;
    logic [9:0]  r_cnt;
    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic [2:0]  r_colour;
    logic        r_grid_draw;
    logic        r_sel_draw;
    logic        r_err;
    logic [7:0]  r_grid_x;
    logic [6:0]  r_grid_y;
    logic [2:0]  r_grid_bg;
    logic [2:0]  r_grid_fg;
    logic [7:0]  r_sel_x;
    logic [6:0]  r_sel_y;
    logic [2:0]  r_sel_colour;

    logic [15:0] w_set;
    logic [15:0] w_clr;
    logic [3:0]  w_low;
    logic [1:0]  w_row;
    logic [1:0]  w_col;
    logic [7:0]  w_ox;
    logic [6:0]  w_oy;
    logic [2:0]  w_bg;
    logic [2:0]  w_fg;
    logic [1:0]  w_cs;
    logic        w_gwait;
    logic        w_swait;

    always_comb begin
        w_set = '0;
        if (mark_valid) w_set[mark_cell] = 1'b1;
        if (sel_move) begin
            w_set[r_sel_q]  = 1'b1;
            w_set[sel_cell] = 1'b1;
        end
        if (redraw_all) w_set = '1;
    end

    always_comb begin
        w_low = '0;
        for (int i = 15; i >= 0; i--)
            if (r_dirty[i]) w_low = 4'(i);
    end

    assign w_row = w_low[3:2];
    assign w_col = w_low[1:0];
    assign w_ox  = X0 + CELL * 8'(w_col);
    assign w_oy  = Y0 + 7'(CELL * 8'(w_row));
    assign w_bg  = (w_row[0] ^ w_col[0]) ? 3'b111 : 3'b000;
    assign w_cs  = cell_state[{w_low, 1'b0} +: 2];
    assign w_clr = (r_state == S_PICK) ? (16'd1 << w_low) : 16'd0;

    always_comb begin
        case (w_cs)
            2'b01:   w_fg = 3'b001;
            2'b10:   w_fg = 3'b110;
            default: w_fg = w_bg;
        endcase
    end

    assign w_gwait = (r_state == S_GRID_WAIT);
    assign w_swait = (r_state == S_SEL_WAIT);

    // Pixels pass straight through while a drawer owns the port.
    assign plot   = (w_gwait & ~grid_done) | (w_swait & ~sel_done);
    assign x      = w_gwait ? grid_px_x : (w_swait ? sel_px_x : r_x);
    assign y      = w_gwait ? grid_px_y : (w_swait ? sel_px_y : r_y);
    assign colour = w_gwait ? grid_px_colour :
                    (w_swait ? sel_px_colour : r_colour);

    assign busy        = (r_state != S_IDLE) | (|r_dirty);
    assign grid_draw   = r_grid_draw;
    assign sel_draw    = r_sel_draw;
    assign timeout_err = r_err;
    assign grid_x      = r_grid_x;
    assign grid_y      = r_grid_y;
    assign grid_bg     = r_grid_bg;
    assign grid_fg     = r_grid_fg;
    assign sel_x       = r_sel_x;
    assign sel_y       = r_sel_y;
    assign sel_colour  = r_sel_colour;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_dirty      <= 16'hFFFF;
            r_sel_q      <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_colour     <= '0;
            r_grid_draw  <= 1'b0;
            r_sel_draw   <= 1'b0;
            r_err        <= 1'b0;
            r_grid_x     <= '0;
            r_grid_y     <= '0;
            r_grid_bg    <= '0;
            r_grid_fg    <= '0;
            r_sel_x      <= '0;
            r_sel_y      <= '0;
            r_sel_colour <= '0;
        end else begin
            r_dirty     <= (r_dirty & ~w_clr) | w_set;
            r_grid_draw <= 1'b0;
            r_sel_draw  <= 1'b0;
            if (sel_move) r_sel_q <= sel_cell;
            if (w_gwait | w_swait) begin
                r_x      <= x;
                r_y      <= y;
                r_colour <= colour;
            end
            case (r_state)
                S_IDLE: begin
                    if (|(r_dirty | w_set)) r_state <= S_PICK;
                end
                S_PICK: begin
                    r_idx       <= w_low;
                    r_grid_x    <= w_ox;
                    r_grid_y    <= w_oy;
                    r_grid_bg   <= w_bg;
                    r_grid_fg   <= w_fg;
                    r_grid_draw <= 1'b1;
                    r_state     <= S_GRID_START;
                end
                S_GRID_START: begin
                    r_cnt   <= '0;
                    r_state <= S_GRID_WAIT;
                end
                S_GRID_WAIT: begin
                    if (grid_done) begin
                        if (r_idx == r_sel_q) begin
                            r_sel_x      <= r_grid_x;
                            r_sel_y      <= r_grid_y;
                            r_sel_colour <= SEL_COLOUR;
                            r_sel_draw   <= 1'b1;
                            r_state      <= S_SEL_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (r_cnt == TIMEOUT - 10'd1) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                S_SEL_START: begin
                    r_cnt   <= '0;
                    r_state <= S_SEL_WAIT;
                end
                S_SEL_WAIT: begin
                    if (sel_done) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == TIMEOUT - 10'd1) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/board_draw_scheduler.md
Name: board_draw_scheduler

Overview:
- Sequences the single VGA pixel-write port between the grid drawer and the selector drawer for the 4x4 play area of the 160x120 screen.
- Keeps a 16-bit dirty bitmap of board cells and redraws dirty cells one at a time.
- For each redraw it computes the cell origin, the checker background and the figure colour, then handshakes with the grid drawer.
- If the redrawn cell holds the selector, it then handshakes with the selector drawer and muxes that drawer's pixels onto x/y/colour/plot.

Parameters:
- X0, 31, x origin of column 0.
- Y0, 11, y origin of row 0.
- CELL, 25, cell pitch in pixels.
- SEL_COLOUR, 3'b100, selector border colour.
- TIMEOUT, 1023, max cycles to wait for a drawer done before aborting (10-bit counter).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cell_state  in  32  2 bits per cell, cell i at [2i+1:2i]: 00 empty, 01 blue, 10 yellow, 11 treated as empty
- mark_valid  in  1  pulse: mark cell mark_cell dirty
- mark_cell  in  4  cell index; row = idx[3:2], col = idx[1:0]
- redraw_all  in  1  pulse: mark all 16 cells dirty
- sel_move  in  1  pulse: selector moves to sel_cell
- sel_cell  in  4  new selector cell
- grid_draw  out  1  one-cycle start pulse to grid drawer
- grid_x / grid_y  out  8 / 7  cell origin
- grid_bg / grid_fg  out  3 / 3  colours
- grid_done  in  1  grid drawer finished
- grid_px_x / grid_px_y / grid_px_colour  in  8 / 7 / 3  grid drawer pixel
- sel_draw  out  1  one-cycle start pulse to selector drawer
- sel_x / sel_y / sel_colour  out  8 / 7 / 3  selector origin and colour
- sel_done  in  1  selector drawer finished
- sel_px_x / sel_px_y / sel_px_colour  in  8 / 7 / 3  selector drawer pixel
- x / y / colour / plot  out  8 / 7 / 3 / 1  to VGA adapter
- busy  out  1  state != IDLE or dirty != 0
- timeout_err  out  1  sticky; set on drawer timeout

Behaviour:
- Reset (async): state IDLE; dirty = 16'hFFFF (full board redraw after reset); sel_q = 0; timeout counter 0. All outputs 0, except busy = 1 because dirty != 0.
- Dirty update each clock. Set sources: mark_valid sets bit mark_cell. redraw_all sets all bits. sel_move sets bits sel_q (old) and sel_cell (new) and loads sel_q <= sel_cell. Clear source: PICK clears the chosen bit. If a set and a clear hit the same bit in the same cycle, set wins.
- IDLE: if dirty != 0, go to PICK.
- PICK (1 cycle): idx = lowest set dirty bit. Latch:
  - grid_x = X0 + CELL*col; grid_y = Y0 + CELL*row, with 8/7-bit unsigned results.
  - grid_bg = 3'b111 if row+col is odd, else 3'b000.
  - grid_fg: 3'b001 (blue) or 3'b110 (yellow) from cell_state sampled this cycle; grid_bg if empty or 11.
  - Then go to GRID_START.
- GRID_START: grid_draw = 1 for exactly one cycle; timeout counter cleared; go to GRID_WAIT.
- GRID_WAIT: plot = 1; x/y/colour = grid_px_*.
  - On grid_done: plot = 0 that cycle. Go to SEL_START if idx == sel_q, else IDLE.
  - If the counter reaches TIMEOUT: set timeout_err; go to IDLE. The cell is not re-marked.
- SEL_START: sel_x/sel_y = origin of sel_q; sel_colour = SEL_COLOUR; sel_draw = 1 for one cycle; go to SEL_WAIT.
- SEL_WAIT: plot = 1; x/y/colour = sel_px_*.
  - On sel_done: go to IDLE.
  - On timeout: same rule as GRID_WAIT.
- plot = 0 in IDLE, PICK, GRID_START and SEL_START. x/y/colour hold their last values there.
- Latency: a mark_valid pulse at cycle N with scheduler idle and dirty empty gives dirty bit at N+1, PICK at N+1, GRID_START (grid_draw high) at N+2.
- grid_x/grid_y/grid_bg/grid_fg stay stable from PICK until the next PICK.
- cell_state changes after PICK do not affect an in-progress draw; the cell must be re-marked.
- sel_move during SEL_WAIT does not abort the draw; old and new cells become dirty and are redrawn later.
- Reset asserted mid-draw: immediate return to reset values; the drawers are reset by the same reset.

Test Plan:
- Release reset, drawers answer done 5 cycles after draw -> 16 grid_draw pulses, idx 0..15 in order. idx0 gives (31,11) bg 000. idx1 gives (56,11) bg 111. idx5 gives (56,36) bg 000. idx0 is followed by a sel_draw at (31,11) colour 100. busy then falls to 0.
- Idle board; cell_state[13:12]=10; mark_valid with mark_cell=6 at cycle N -> grid_draw at N+2 with grid_x=81, grid_y=36, bg=111, fg=110. No sel_draw.
- sel_move with sel_cell=15 while sel_q=0 -> cell 0 redrawn without selector. Cell 15 redrawn at (106,86), then sel_draw at (106,86).
- mark_valid on the cell whose bit is being cleared in PICK (same cycle) -> bit stays set; the cell is drawn twice.
- grid_done never asserted -> after 1023 GRID_WAIT cycles timeout_err = 1, state IDLE, the next dirty cell proceeds.
- Assert reset during GRID_WAIT -> plot, grid_draw and sel_draw go to 0 asynchronously. After release, a full 16-cell redraw is issued again.
